rename_map_unit: RTL and testbench

- Parametrised, WIDTH-wide register rename stage. It sits between decode and dispatch in the out-of-order core.
- Maintains:
  - speculative map (RAT)
  - committed map (CMT)
  - circular physical free list
  - per-preg ready map
- Renames up to WIDTH instructions per cycle, with intra-group dependency bypass and all-or-nothing stall.
- Releases up to WIDTH old pregs per cycle on commit. Restores RAT from CMT on recovery.

---
 rtl/rename_pkg.sv | 18 +
 rtl/rename_free_list.sv | 70 +++++++
 rtl/rename_map_unit.sv | 159 +++++++++++++++
 tb/tb_rename_map_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and default sizes for the register rename stage.
package rename_pkg;
  localparam int NUM_AREG_DEF = 64;
  localparam int NUM_PREG_DEF = 96;
  localparam int AREG_W = $clog2(NUM_AREG_DEF);
  localparam int PREG_W = $clog2(NUM_PREG_DEF);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  alloc;
    areg_t rs1;
    areg_t rs2;
    areg_t rd;
  } rename_slot_t;
endpackage

// File: rtl/rename_free_list.sv
// Circular physical free list: multi-pop from alloc_ptr, multi-push at rel_ptr,
// wrap-bit pointers, free count and rewind of alloc_ptr on recovery.
module rename_free_list #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 96,
  parameter int WIDTH    = 2,
  localparam int PW       = $clog2(NUM_PREG),
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG,
  localparam int IW       = $clog2(FL_DEPTH),
  localparam int CW       = $clog2(FL_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pop_en,
  input  logic [CW-1:0]             pop_count,
  output logic [WIDTH-1:0][PW-1:0]  peek,
  input  logic [WIDTH-1:0]          push_valid,
  input  logic [WIDTH-1:0][PW-1:0]  push_preg,
  input  logic                      recover,
  output logic [CW-1:0]             free_count
);

  logic [PW-1:0]            entries [FL_DEPTH];
  logic [IW:0]              a_ptr, r_ptr, r_next;
  logic [WIDTH-1:0][IW-1:0] push_idx;

  // MSB of a pointer is the wrap bit; the index wraps modulo FL_DEPTH.
  function automatic logic [IW:0] adv(input logic [IW:0] ptr, input int n);
    int s;
    s = int'(ptr[IW-1:0]) + n;
    if (s >= FL_DEPTH) adv = {~ptr[IW], IW'(s - FL_DEPTH)};
    else               adv = {ptr[IW], IW'(s)};
  endfunction

  always_comb begin
    int n;
    int used;
    logic [IW:0] t;
    n = 0;
    t = '0;
    for (int k = 0; k < WIDTH; k++) begin
      t = adv(a_ptr, k);
      peek[k] = entries[t[IW-1:0]];
    end
    for (int j = 0; j < WIDTH; j++) begin
      t = adv(r_ptr, n);
      push_idx[j] = t[IW-1:0];
      if (push_valid[j]) n++;
    end
    r_next = adv(r_ptr, n);
    used = int'(a_ptr[IW-1:0]) - int'(r_ptr[IW-1:0])
         + ((a_ptr[IW] != r_ptr[IW]) ? FL_DEPTH : 0);
    free_count = CW'(FL_DEPTH - used);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) entries[k] <= PW'(NUM_AREG + k);
      a_ptr <= '0;
      r_ptr <= '0;
    end else begin
      for (int j = 0; j < WIDTH; j++)
        if (push_valid[j]) entries[push_idx[j]] <= push_preg[j];
      r_ptr <= r_next;
      if (recover)     a_ptr <= r_next;
      else if (pop_en) a_ptr <= adv(a_ptr, int'(pop_count));
    end
  end

endmodule

// File: rtl/rename_map_unit.sv
// WIDTH-wide rename stage: RAT, committed map, ready map and free list.
// Optional RENAME_ZERO_REG_EN pins areg 0 to preg 0 (never renamed, always ready).
module rename_map_unit
  import rename_pkg::*;
#(
  parameter int NUM_AREG = NUM_AREG_DEF,
  parameter int NUM_PREG = NUM_PREG_DEF,
  parameter int WIDTH    = 2,
  parameter int NUM_WB   = 2,
  localparam int AW       = $clog2(NUM_AREG),
  localparam int PW       = $clog2(NUM_PREG),
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG,
  localparam int CW       = $clog2(FL_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           slot_valid,
  input  logic [WIDTH-1:0]           alloc,
  input  logic [WIDTH-1:0][AW-1:0]   a_rs1,
  input  logic [WIDTH-1:0][AW-1:0]   a_rs2,
  input  logic [WIDTH-1:0][AW-1:0]   a_rd,
  output logic [WIDTH-1:0][PW-1:0]   p_rs1,
  output logic [WIDTH-1:0][PW-1:0]   p_rs2,
  output logic [WIDTH-1:0]           p_rs1_rdy,
  output logic [WIDTH-1:0]           p_rs2_rdy,
  output logic [WIDTH-1:0][PW-1:0]   p_rd_new,
  output logic [WIDTH-1:0][PW-1:0]   p_rd_old,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB-1:0][PW-1:0]  wb_preg,
  input  logic [WIDTH-1:0]           commit_valid,
  input  logic [WIDTH-1:0][AW-1:0]   commit_areg,
  input  logic [WIDTH-1:0][PW-1:0]   commit_pnew,
  input  logic [WIDTH-1:0][PW-1:0]   commit_pold,
  input  logic                       recovery,
  output logic [CW-1:0]              free_count
);

  logic [PW-1:0]           rat      [NUM_AREG];
  logic [PW-1:0]           cmt      [NUM_AREG];
  logic [PW-1:0]           cmt_next [NUM_AREG];
  logic [NUM_PREG-1:0]     ready_map;
  logic [WIDTH-1:0]        alloc_eff, rel_valid;
  logic [WIDTH-1:0][PW-1:0] fl_peek;
  logic [CW-1:0]           n_alloc;
  logic                    fire;

  always_comb begin
    int n;
    n = 0;
    for (int j = 0; j < WIDTH; j++) begin
      alloc_eff[j] = slot_valid[j] & alloc[j];
      rel_valid[j] = commit_valid[j];
`ifdef RENAME_ZERO_REG_EN
      if (a_rd[j] == '0) alloc_eff[j] = 1'b0;
      if (commit_areg[j] == '0) rel_valid[j] = 1'b0;
`endif
      p_rd_new[j] = '0;
      if (alloc_eff[j]) begin
        p_rd_new[j] = fl_peek[n];
        n++;
      end
    end
    n_alloc = CW'(n);
  end

  assign in_ready = !recovery && (free_count >= n_alloc);
  assign fire     = in_valid && in_ready;

  // Sources and old mapping: RAT read, then younger in-group writers override.
  always_comb begin
    logic [AW-1:0] a;
    logic [PW-1:0] p;
    logic          r;
    a = '0;
    p = '0;
    r = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int s = 0; s < 2; s++) begin
        a = (s == 0) ? a_rs1[j] : a_rs2[j];
        p = rat[a];
        r = ready_map[p];
        for (int w = 0; w < NUM_WB; w++)
          if (wb_valid[w] && wb_preg[w] == p) r = 1'b1;
        for (int k = 0; k < j; k++)
          if (alloc_eff[k] && a_rd[k] == a) begin
            p = p_rd_new[k];
            r = 1'b0;
          end
`ifdef RENAME_ZERO_REG_EN
        if (a == '0) begin
          p = '0;
          r = 1'b1;
        end
`endif
        if (s == 0) begin
          p_rs1[j] = p;
          p_rs1_rdy[j] = r;
        end else begin
          p_rs2[j] = p;
          p_rs2_rdy[j] = r;
        end
      end
      p = rat[a_rd[j]];
      for (int k = 0; k < j; k++)
        if (alloc_eff[k] && a_rd[k] == a_rd[j]) p = p_rd_new[k];
      p_rd_old[j] = p;
    end
  end

  always_comb begin
    cmt_next = cmt;
    for (int j = 0; j < WIDTH; j++)
      if (rel_valid[j]) cmt_next[commit_areg[j]] = commit_pnew[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat[i] <= PW'(i);
        cmt[i] <= PW'(i);
      end
      ready_map <= '1;
    end else begin
      cmt <= cmt_next;
      if (recovery) begin
        rat       <= cmt_next;
        ready_map <= '1;
      end else begin
        if (fire)
          for (int j = 0; j < WIDTH; j++)
            if (alloc_eff[j]) begin
              rat[a_rd[j]]          <= p_rd_new[j];
              ready_map[p_rd_new[j]] <= 1'b0;
            end
        for (int w = 0; w < NUM_WB; w++)
          if (wb_valid[w]) ready_map[wb_preg[w]] <= 1'b1;
      end
    end
  end

  rename_free_list #(
    .NUM_AREG (NUM_AREG),
    .NUM_PREG (NUM_PREG),
    .WIDTH    (WIDTH)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_en     (fire),
    .pop_count  (n_alloc),
    .peek       (fl_peek),
    .push_valid (rel_valid),
    .push_preg  (commit_pold),
    .recover    (recovery),
    .free_count (free_count)
  );

endmodule

// File: tb/tb_rename_map_unit.sv
// Directed self-checking bench for rename_map_unit (default 64 aregs, 96 pregs, 2 slots).
module tb_rename_map_unit;
  import rename_pkg::*;

  localparam int WIDTH = 2, NUM_WB = 2, AW = 6, PW = 7, CW = 6, FL_DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, recovery;
  logic [WIDTH-1:0] slot_valid, alloc, p_rs1_rdy, p_rs2_rdy, commit_valid;
  logic [WIDTH-1:0][AW-1:0] a_rs1, a_rs2, a_rd, commit_areg;
  logic [WIDTH-1:0][PW-1:0] p_rs1, p_rs2, p_rd_new, p_rd_old, commit_pnew, commit_pold;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB-1:0][PW-1:0] wb_preg;
  logic [CW-1:0] free_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rename_map_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .slot_valid(slot_valid), .alloc(alloc), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd),
    .p_rs1(p_rs1), .p_rs2(p_rs2), .p_rs1_rdy(p_rs1_rdy), .p_rs2_rdy(p_rs2_rdy),
    .p_rd_new(p_rd_new), .p_rd_old(p_rd_old), .wb_valid(wb_valid), .wb_preg(wb_preg),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_pnew(commit_pnew),
    .commit_pold(commit_pold), .recovery(recovery), .free_count(free_count)
  );

  // Protocol rules the environment must honour.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < WIDTH; j++)
        for (int w = 0; w < NUM_WB; w++)
          if (in_valid && in_ready && slot_valid[j] && alloc[j] && wb_valid[w]
              && wb_preg[w] == p_rd_new[j]) begin
            miscompares++;
            $display("FAIL alloc_wb_clash slot %0d preg %0d", j, p_rd_new[j]);
          end
      if (free_count == CW'(FL_DEPTH) && |commit_valid) begin
        miscompares++;
        $display("FAIL commit_on_full free_count %0d", free_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; recovery = 0; slot_valid = '0; alloc = '0;
    a_rs1 = '0; a_rs2 = '0; a_rd = '0; wb_valid = '0; wb_preg = '0;
    commit_valid = '0; commit_areg = '0; commit_pnew = '0; commit_pold = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  function automatic rename_slot_t mk(logic v, logic al, int rs1, int rs2, int rd);
    rename_slot_t s;
    s.valid = v; s.alloc = al; s.rs1 = areg_t'(rs1); s.rs2 = areg_t'(rs2); s.rd = areg_t'(rd);
    return s;
  endfunction

  task automatic set_slot(int j, rename_slot_t s);
    slot_valid[j] = s.valid; alloc[j] = s.alloc;
    a_rs1[j] = s.rs1; a_rs2[j] = s.rs2; a_rd[j] = s.rd;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (free_count !== 6'd32) begin miscompares++; $display("FAIL reset_free_count got %0d exp 32", free_count); end
    set_slot(0, mk(1, 1, 13, 0, 3)); set_slot(1, mk(1, 1, 0, 63, 4));
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    vectors++; if (p_rs1[0] !== 7'd13 || p_rs1_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL reset_rat13 got %0d/%0b exp 13/1", p_rs1[0], p_rs1_rdy[0]); end
    vectors++; if (p_rs2[1] !== 7'd63 || p_rs2_rdy[1] !== 1'b1) begin miscompares++; $display("FAIL reset_rat63 got %0d/%0b exp 63/1", p_rs2[1], p_rs2_rdy[1]); end
    clear_inputs();
  endtask

  task automatic test_rename_bypass();
    do_reset();
    set_slot(0, mk(1, 1, 1, 2, 5)); set_slot(1, mk(1, 1, 5, 3, 6));
    in_valid = 1;
    @(negedge clk);
    vectors++; if (p_rd_new[0] !== 7'd64 || p_rd_new[1] !== 7'd65) begin miscompares++; $display("FAIL byp_rd_new got %0d,%0d exp 64,65", p_rd_new[0], p_rd_new[1]); end
    vectors++; if (p_rs1[1] !== 7'd64 || p_rs1_rdy[1] !== 1'b0) begin miscompares++; $display("FAIL byp_rs1 got %0d/%0b exp 64/0", p_rs1[1], p_rs1_rdy[1]); end
    vectors++; if (p_rd_old[0] !== 7'd5 || p_rd_old[1] !== 7'd6) begin miscompares++; $display("FAIL byp_rd_old got %0d,%0d exp 5,6", p_rd_old[0], p_rd_old[1]); end
    tick();
    clear_inputs();
    set_slot(0, mk(0, 0, 5, 6, 0));
    #1;
    vectors++; if (free_count !== 6'd30) begin miscompares++; $display("FAIL byp_free_count got %0d exp 30", free_count); end
    vectors++; if (p_rs1[0] !== 7'd64 || p_rs1_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL byp_rat5 got %0d/%0b exp 64/0", p_rs1[0], p_rs1_rdy[0]); end
    vectors++; if (p_rs2[0] !== 7'd65) begin miscompares++; $display("FAIL byp_rat6 got %0d exp 65", p_rs2[0]); end
    clear_inputs();
  endtask

  task automatic test_same_rd();
    do_reset();
    set_slot(0, mk(1, 1, 0, 0, 7)); set_slot(1, mk(1, 1, 0, 0, 7));
    in_valid = 1;
    @(negedge clk);
    vectors++; if (p_rd_new[0] !== 7'd64 || p_rd_new[1] !== 7'd65) begin miscompares++; $display("FAIL same_rd_new got %0d,%0d exp 64,65", p_rd_new[0], p_rd_new[1]); end
    vectors++; if (p_rd_old[0] !== 7'd7 || p_rd_old[1] !== 7'd64) begin miscompares++; $display("FAIL same_rd_old got %0d,%0d exp 7,64", p_rd_old[0], p_rd_old[1]); end
    tick();
    clear_inputs();
    a_rs1[0] = 7;
    #1;
    vectors++; if (p_rs1[0] !== 7'd65) begin miscompares++; $display("FAIL same_rd_rat7 got %0d exp 65", p_rs1[0]); end
    clear_inputs();
  endtask

  task automatic test_full_and_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_slot(0, mk(1, 1, 0, 0, 2 * i + 1)); set_slot(1, mk(1, 1, 0, 0, 2 * i + 2));
      in_valid = 1;
      @(negedge clk);
      if (i == 15) begin
        vectors++; if (p_rd_new[1] !== 7'd95) begin miscompares++; $display("FAIL full_last_preg got %0d exp 95", p_rd_new[1]); end
      end
      tick();
    end
    clear_inputs();
    vectors++; if (free_count !== 6'd0) begin miscompares++; $display("FAIL full_free_count got %0d exp 0", free_count); end
    set_slot(0, mk(1, 0, 1, 2, 0)); set_slot(1, mk(1, 1, 0, 0, 40));
    in_valid = 1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_block_alloc got %0b exp 0", in_ready); end
    alloc = '0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pass_nonalloc got %0b exp 1", in_ready); end
    tick();
    clear_inputs();
    commit_valid = 2'b11;
    commit_areg[0] = 1; commit_pnew[0] = 64; commit_pold[0] = 20;
    commit_areg[1] = 2; commit_pnew[1] = 65; commit_pold[1] = 21;
    tick();
    clear_inputs();
    vectors++; if (free_count !== 6'd2) begin miscompares++; $display("FAIL wrap_free_count got %0d exp 2", free_count); end
    set_slot(0, mk(1, 1, 0, 0, 50)); set_slot(1, mk(1, 1, 0, 0, 51));
    in_valid = 1;
    @(negedge clk);
    vectors++; if (p_rd_new[0] !== 7'd20 || p_rd_new[1] !== 7'd21) begin miscompares++; $display("FAIL wrap_rd_new got %0d,%0d exp 20,21", p_rd_new[0], p_rd_new[1]); end
    tick();
    clear_inputs();
    vectors++; if (free_count !== 6'd0) begin miscompares++; $display("FAIL wrap_refill got %0d exp 0", free_count); end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    set_slot(0, mk(1, 1, 0, 0, 5));
    in_valid = 1;
    tick();
    clear_inputs();
    set_slot(0, mk(1, 0, 5, 0, 0));
    in_valid = 1;
    #1;
    vectors++; if (p_rs1[0] !== 7'd64 || p_rs1_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL wb_pending got %0d/%0b exp 64/0", p_rs1[0], p_rs1_rdy[0]); end
    wb_valid[1] = 1; wb_preg[1] = 64;
    @(negedge clk);
    vectors++; if (p_rs1_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL wb_bypass_rdy got %0b exp 1", p_rs1_rdy[0]); end
    tick();
    clear_inputs();
    a_rs2[1] = 5;
    #1;
    vectors++; if (p_rs2[1] !== 7'd64 || p_rs2_rdy[1] !== 1'b1) begin miscompares++; $display("FAIL wb_ready_map got %0d/%0b exp 64/1", p_rs2[1], p_rs2_rdy[1]); end
  endtask

  task automatic test_recovery();
    do_reset();
    set_slot(0, mk(1, 1, 0, 0, 5)); set_slot(1, mk(1, 1, 0, 0, 6));
    in_valid = 1;
    tick();
    clear_inputs();
    set_slot(0, mk(1, 1, 0, 0, 9));
    in_valid = 1;
    tick();
    vectors++; if (free_count !== 6'd29) begin miscompares++; $display("FAIL rec_pre_count got %0d exp 29", free_count); end
    set_slot(0, mk(1, 1, 0, 0, 12));
    recovery = 1;
    commit_valid = 2'b11;
    commit_areg[0] = 5; commit_pnew[0] = 64; commit_pold[0] = 5;
    commit_areg[1] = 6; commit_pnew[1] = 65; commit_pold[1] = 6;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rec_in_ready got %0b exp 0", in_ready); end
    tick();
    clear_inputs();
    a_rs1[0] = 5; a_rs2[0] = 6; a_rs1[1] = 9;
    #1;
    vectors++; if (free_count !== 6'd32) begin miscompares++; $display("FAIL rec_free_count got %0d exp 32", free_count); end
    vectors++; if (p_rs1[0] !== 7'd64 || p_rs1_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL rec_rat5 got %0d/%0b exp 64/1", p_rs1[0], p_rs1_rdy[0]); end
    vectors++; if (p_rs2[0] !== 7'd65) begin miscompares++; $display("FAIL rec_rat6 got %0d exp 65", p_rs2[0]); end
    vectors++; if (p_rs1[1] !== 7'd9) begin miscompares++; $display("FAIL rec_rat9 got %0d exp 9", p_rs1[1]); end
    clear_inputs();
    set_slot(0, mk(1, 1, 0, 0, 10)); set_slot(1, mk(1, 1, 0, 0, 11));
    in_valid = 1;
    @(negedge clk);
    vectors++; if (p_rd_new[0] !== 7'd66 || p_rd_new[1] !== 7'd67) begin miscompares++; $display("FAIL rec_next_alloc got %0d,%0d exp 66,67", p_rd_new[0], p_rd_new[1]); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_slot(0, mk(1, 1, 0, 0, 5)); set_slot(1, mk(1, 1, 0, 0, 8));
    in_valid = 1;
    tick();
    clear_inputs();
    rst = 1;
    commit_valid = 2'b01; commit_areg[0] = 5; commit_pnew[0] = 64; commit_pold[0] = 5;
    tick();
    rst = 0;
    clear_inputs();
    a_rs1[0] = 5;
    #1;
    vectors++; if (free_count !== 6'd32) begin miscompares++; $display("FAIL midrst_free_count got %0d exp 32", free_count); end
    vectors++; if (p_rs1[0] !== 7'd5 || p_rs1_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_rat5 got %0d/%0b exp 5/1", p_rs1[0], p_rs1_rdy[0]); end
    set_slot(0, mk(1, 1, 0, 0, 3));
    #1;
    vectors++; if (p_rd_new[0] !== 7'd64) begin miscompares++; $display("FAIL midrst_alloc got %0d exp 64", p_rd_new[0]); end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_slot(0, mk(1, 1, 0, 0, 0)); set_slot(1, mk(1, 0, 0, 0, 0));
    in_valid = 1;
    @(negedge clk);
`ifdef RENAME_ZERO_REG_EN
    vectors++; if (p_rd_new[0] !== 7'd0) begin miscompares++; $display("FAIL zero_rd_new got %0d exp 0", p_rd_new[0]); end
    vectors++; if (p_rs1[1] !== 7'd0 || p_rs1_rdy[1] !== 1'b1) begin miscompares++; $display("FAIL zero_src got %0d/%0b exp 0/1", p_rs1[1], p_rs1_rdy[1]); end
    tick();
    clear_inputs();
    vectors++; if (free_count !== 6'd32) begin miscompares++; $display("FAIL zero_free_count got %0d exp 32", free_count); end
`else
    vectors++; if (p_rd_new[0] !== 7'd64) begin miscompares++; $display("FAIL zero_rd_new got %0d exp 64", p_rd_new[0]); end
    vectors++; if (p_rs1[1] !== 7'd64 || p_rs1_rdy[1] !== 1'b0) begin miscompares++; $display("FAIL zero_src got %0d/%0b exp 64/0", p_rs1[1], p_rs1_rdy[1]); end
    tick();
    clear_inputs();
    vectors++; if (free_count !== 6'd31) begin miscompares++; $display("FAIL zero_free_count got %0d exp 31", free_count); end
`endif
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    test_reset();
    test_rename_bypass();
    test_same_rd();
    test_full_and_wrap();
    test_wb_bypass();
    test_recovery();
    test_reset_midop();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
